// File: rtl/cpu_run_monitor_if.sv
// Writeback log stream between the run monitor (master) and its consumer (slave).
`timescale 1ns/1ps
interface cpu_run_monitor_if #(
    parameter int unsigned PC_W = 32
) ();
    logic            log_valid;
    logic            log_ready;
    logic [PC_W-1:0] log_pc;
    logic [4:0]      log_addr;
    logic [31:0]     log_data;

    modport master (output log_valid, log_pc, log_addr, log_data, input log_ready);
    modport slave  (input log_valid, log_pc, log_addr, log_data, output log_ready);
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle MIPS core: holds the core in reset, counts
// cycles/retires, detects program end or timeout, and logs register writebacks.
`timescale 1ns/1ps
module cpu_run_monitor #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned TIMEOUT     = 100000,
    parameter logic [31:0] HALT_INSTR  = 32'h0000000c,
    parameter int unsigned LOG_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     cpu_reset,
    input  logic [PC_W-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic                     retire,
    input  logic                     wb_en,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    output logic                     running,
    output logic                     done,
    output logic                     timed_out,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instr_cnt,
    cpu_run_monitor_if.master        log_if
);

    localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned SAME_W = $clog2(STALL_LIMIT + 1);
    localparam int unsigned PTR_W  = $clog2(LOG_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      addr;
        logic [31:0]     data;
    } log_entry_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_run;
    logic [RST_W-1:0]    rst_cnt;

    logic [PC_W-1:0]     last_pc;
    logic                last_vld;
    logic [SAME_W-1:0]   same_cnt;

    log_entry_t          mem [LOG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [FCNT_W-1:0]   fcnt;
    logic [FCNT_W-1:0]   fcnt_nxt;
    log_entry_t          head;
    log_entry_t          head_nxt;
    log_entry_t          entry_in;
    logic                log_valid_q;

    logic in_run, ret_run, same_hit, halt_instr, halt_stall, halt, tmo;
    logic push, pop, full, wr_ok;

    // Run-state decode shared by the FSM, counters and log
    always_comb begin
        in_run     = (state == S_RUN);
        ret_run    = in_run && retire;
        same_hit   = last_vld && (pc == last_pc);
        halt_instr = ret_run && (instr == HALT_INSTR);
        halt_stall = ret_run && same_hit && (same_cnt == SAME_W'(STALL_LIMIT - 1));
        halt       = halt_instr || halt_stall;
        tmo        = in_run && !halt && (cycle_cnt == CNT_W'(TIMEOUT - 1));
        push       = ret_run && wb_en && (wb_addr != 5'd0);
        pop        = log_valid_q && log_if.log_ready;
        full       = (fcnt == FCNT_W'(LOG_DEPTH));
        wr_ok      = push && (!full || pop);
        entry_in   = {pc, wb_addr, wb_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RST;
                    start_run = 1'b1;
                end
            end
            S_RST:   if (rst_cnt == '0) state_nxt = S_RUN;
            S_RUN:   if (halt || tmo) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt   <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cpu_reset <= (state_nxt != S_RUN);
            running   <= (state_nxt == S_RUN);
            done      <= (state_nxt == S_DONE);
            if (start_run)
                rst_cnt <= RST_W'(RST_CYCLES - 1);
            else if (state == S_RST && rst_cnt != '0)
                rst_cnt <= rst_cnt - RST_W'(1);
            if (start_run)  timed_out <= 1'b0;
            else if (tmo)   timed_out <= 1'b1;
            if (start_run)            overflow <= 1'b0;
            else if (push && !wr_ok)  overflow <= 1'b1;
        end
    end

    // cycle_cnt freezes on the exit cycle, so it ends holding the index of the last RUN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            last_pc   <= '0;
            last_vld  <= 1'b0;
            same_cnt  <= '0;
        end else if (start_run) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            last_vld  <= 1'b0;
            same_cnt  <= '0;
        end else begin
            if (in_run && state_nxt == S_RUN && cycle_cnt != CNT_MAX)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ret_run && instr_cnt != CNT_MAX)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (ret_run) begin
                last_pc  <= pc;
                last_vld <= 1'b1;
                same_cnt <= same_hit ? same_cnt + SAME_W'(1) : SAME_W'(1);
            end
        end
    end

    // Next occupancy and next registered head entry
    always_comb begin
        case ({wr_ok, pop})
            2'b10:   fcnt_nxt = fcnt + FCNT_W'(1);
            2'b01:   fcnt_nxt = fcnt - FCNT_W'(1);
            default: fcnt_nxt = fcnt;
        endcase
        if (start_run) fcnt_nxt = '0;

        head_nxt = head;
        if (fcnt_nxt == '0)
            head_nxt = '0;
        else if (fcnt == '0)
            head_nxt = entry_in;
        else if (pop)
            head_nxt = (fcnt == FCNT_W'(1)) ? entry_in : mem[rd_ptr + PTR_W'(1)];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= entry_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fcnt        <= '0;
            head        <= '0;
            log_valid_q <= 1'b0;
        end else begin
            fcnt        <= fcnt_nxt;
            head        <= head_nxt;
            log_valid_q <= (fcnt_nxt != '0);
            if (start_run) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign log_if.log_valid = log_valid_q;
    assign log_if.log_pc    = head.pc;
    assign log_if.log_addr  = head.addr;
    assign log_if.log_data  = head.data;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed vector table, hand sequences for multi-cycle
// corners, then random stimulus against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cpu_run_monitor;

    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned STALL_LIMIT = 8;
    localparam int unsigned TIMEOUT     = 20;
    localparam int unsigned LOG_DEPTH   = 4;
    localparam logic [31:0] HALT        = 32'h0000000c;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, retire, wb_en;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;
    logic        cpu_reset, running, done, timed_out, overflow;
    logic [31:0] cycle_cnt, instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_run_monitor_if #(.PC_W(32)) log_bus ();

    cpu_run_monitor #(
        .PC_W(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES), .STALL_LIMIT(STALL_LIMIT),
        .TIMEOUT(TIMEOUT), .HALT_INSTR(HALT), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cpu_reset(cpu_reset),
        .pc(pc), .instr(instr), .retire(retire), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .running(running), .done(done),
        .timed_out(timed_out), .overflow(overflow), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt), .log_if(log_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 1'b0; retire = 1'b0; instr = 32'h0; pc = 32'h0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    endtask

    task automatic ret(input logic [31:0] p, input logic [31:0] ins, input logic we,
                       input logic [4:0] a, input logic [31:0] d);
        retire = 1'b1; pc = p; instr = ins; wb_en = we; wb_addr = a; wb_data = d;
    endtask

    // Pulse start and wait (bounded) for the first RUN cycle
    task automatic begin_run();
        idle_in();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16 && !running; i++) tick();
        check("run_entry", running, 1'b1);
        check("run_cyc0", cycle_cnt, 32'd0);
    endtask

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DONE = 3;
    typedef struct packed { logic [31:0] pc; logic [4:0] a; logic [31:0] d; } ent_t;

    int          m_phase;
    int          m_rst_left;
    logic [31:0] m_cyc, m_ins;
    logic        m_to, m_ovf;
    ent_t        m_q[$];
    logic [31:0] m_hist[$];

    task automatic model_reset();
        m_phase = P_IDLE; m_rst_left = 0; m_cyc = '0; m_ins = '0;
        m_to = 1'b0; m_ovf = 1'b0; m_q.delete(); m_hist.delete();
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_step();
        bit   pop, halt, tmo, same;
        ent_t e;
        pop = (m_q.size() > 0) && log_bus.log_ready;
        if (m_phase == P_IDLE || m_phase == P_DONE) begin
            if (start) begin
                m_phase = P_RST; m_rst_left = RST_CYCLES;
                m_cyc = '0; m_ins = '0; m_to = 1'b0; m_ovf = 1'b0;
                m_q.delete(); m_hist.delete();
                return;
            end
            if (pop) void'(m_q.pop_front());
        end else if (m_phase == P_RST) begin
            if (pop) void'(m_q.pop_front());
            m_rst_left--;
            if (m_rst_left == 0) m_phase = P_RUN;
        end else begin
            if (pop) void'(m_q.pop_front());
            halt = 1'b0;
            if (retire) begin
                if (m_ins != 32'hffff_ffff) m_ins++;
                m_hist.push_back(pc);
                if (instr == HALT) halt = 1'b1;
                if (m_hist.size() >= STALL_LIMIT) begin
                    same = 1'b1;
                    for (int i = 0; i < STALL_LIMIT; i++)
                        if (m_hist[m_hist.size() - 1 - i] != pc) same = 1'b0;
                    if (same) halt = 1'b1;
                end
                if (wb_en && wb_addr != 5'd0) begin
                    e = {pc, wb_addr, wb_data};
                    if (m_q.size() < LOG_DEPTH) m_q.push_back(e);
                    else m_ovf = 1'b1;
                end
            end
            tmo = !halt && (m_cyc == TIMEOUT - 1);
            if (halt || tmo) begin
                m_phase = P_DONE;
                if (tmo) m_to = 1'b1;
            end else if (m_cyc != 32'hffff_ffff) begin
                m_cyc++;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        start, retire;
        logic [31:0] instr, pc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        e_cr, e_run, e_done, e_to;
        logic [31:0] e_cyc, e_icnt;
        logic        e_lv;
    } vec_t;

    vec_t tbl[10];

    initial begin
        ent_t hd;
        // start in cycle 0; a second start while in reset must be ignored
        tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h20010011, 32'h3000, 1'b1, 5'd1, 32'h11,  1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h20000022, 32'h3004, 1'b1, 5'd0, 32'h22,  1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h00000000, 32'h3008, 1'b0, 5'd0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 1'b1};
        tbl[8] = '{1'b0, 1'b1, HALT,         32'h300c, 1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 32'h20030033, 32'h3010, 1'b1, 5'd3, 32'h33,  1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 1'b1};

        idle_in();
        log_bus.log_ready = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_flags", {running, done, timed_out, overflow, log_bus.log_valid}, 5'b0);
        check("rst_counters", {cycle_cnt, instr_cnt}, 64'd0);
        check("rst_head", {log_bus.log_pc, log_bus.log_addr, log_bus.log_data}, 69'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; retire = tbl[i].retire; instr = tbl[i].instr; pc = tbl[i].pc;
            wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
            tick();
            check($sformatf("vec%0d_cpu_reset", i), cpu_reset, tbl[i].e_cr);
            check($sformatf("vec%0d_running", i), running, tbl[i].e_run);
            check($sformatf("vec%0d_done_to", i), {done, timed_out}, {tbl[i].e_done, tbl[i].e_to});
            check($sformatf("vec%0d_cycle_cnt", i), cycle_cnt, tbl[i].e_cyc);
            check($sformatf("vec%0d_instr_cnt", i), instr_cnt, tbl[i].e_icnt);
            check($sformatf("vec%0d_log_valid", i), log_bus.log_valid, tbl[i].e_lv);
        end
        idle_in();
        // only $1 was logged: $0 write and the post-halt write are dropped
        check("tbl_head", {log_bus.log_pc, log_bus.log_addr, log_bus.log_data}, {32'h3000, 5'd1, 32'h11});
        log_bus.log_ready = 1'b1;
        tick();
        check("tbl_drained", log_bus.log_valid, 1'b0);
        log_bus.log_ready = 1'b0;

        // stall detector: beq self-loop
        begin_run();
        for (int k = 1; k <= 8; k++) begin
            ret(32'h3010, 32'h1000ffff, 1'b0, 5'd0, 32'h0);
            tick();
            if (k == 7) check("stall_not_yet", {done, instr_cnt}, {1'b0, 32'd7});
        end
        idle_in();
        check("stall_done", {done, timed_out, cpu_reset}, 3'b101);
        check("stall_icnt", instr_cnt, 32'd8);

        // timeout with no halt
        begin_run();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) check("tmo_before", {done, cycle_cnt}, {1'b0, 32'd19});
        end
        check("tmo_flags", {done, timed_out, cpu_reset, running}, 4'b1110);
        check("tmo_cycle_cnt", cycle_cnt, 32'd19);

        // halt on the timeout cycle wins
        begin_run();
        repeat (19) tick();
        ret(32'h4000, HALT, 1'b0, 5'd0, 32'h0);
        tick();
        idle_in();
        check("halt19_flags", {done, timed_out}, 2'b10);
        check("halt19_counts", {cycle_cnt, instr_cnt}, {32'd19, 32'd1});

        // overflow: six writebacks into a 4-deep log with no consumer
        begin_run();
        for (int k = 1; k <= 6; k++) begin
            ret(32'h5000 + 32'(4 * k), 32'h20000000, 1'b1, 5'(k), 32'(8'h11 * k));
            tick();
        end
        idle_in();
        check("ovf_flag", {overflow, log_bus.log_valid}, 2'b11);
        log_bus.log_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_pop%0d", k), {log_bus.log_pc, log_bus.log_addr, log_bus.log_data},
                  {32'h5000 + 32'(4 * k), 5'(k), 32'(8'h11 * k)});
            tick();
        end
        check("ovf_drained", log_bus.log_valid, 1'b0);
        log_bus.log_ready = 1'b0;
        ret(32'h5100, HALT, 1'b0, 5'd0, 32'h0);
        tick();
        idle_in();

        // push and pop together while full
        begin_run();
        check("full_ovf_cleared", overflow, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            ret(32'h6000 + 32'(4 * k), 32'h20000000, 1'b1, 5'(k), 32'hA0 + 32'(k));
            tick();
        end
        ret(32'h6014, 32'h20000000, 1'b1, 5'd5, 32'hA5);
        log_bus.log_ready = 1'b1;
        tick();
        idle_in();
        check("full_pushpop_ovf", {overflow, log_bus.log_valid}, 2'b01);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("full_pop%0d", k), {log_bus.log_addr, log_bus.log_data}, {5'(k), 32'hA0 + 32'(k)});
            tick();
        end
        check("full_drained", log_bus.log_valid, 1'b0);
        log_bus.log_ready = 1'b0;

        // asynchronous reset in the middle of a run
        ret(32'h7000, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        ret(32'h7004, 32'h20010001, 1'b1, 5'd1, 32'h1);
        tick();
        idle_in();
        check("mid_running", {running, instr_cnt}, {1'b1, 32'd7});
        #2 reset = 1'b0;
        #1;
        check("mid_rst_flags", {cpu_reset, running, done, timed_out, overflow, log_bus.log_valid}, 6'b100000);
        check("mid_rst_counters", {cycle_cnt, instr_cnt}, 64'd0);
        check("mid_rst_head", {log_bus.log_pc, log_bus.log_addr, log_bus.log_data}, 69'd0);

        // randomized run against the reference model
        tick();
        reset = 1'b1;
        model_reset();
        pc = 32'h1000;
        for (int c = 0; c < 2500; c++) begin
            hd = (m_q.size() > 0) ? m_q[0] : '0;
            check("rand_flags", {cpu_reset, running, done, timed_out, overflow, log_bus.log_valid},
                  {m_phase != P_RUN, m_phase == P_RUN, m_phase == P_DONE, m_to, m_ovf, m_q.size() > 0});
            check("rand_counts", {cycle_cnt, instr_cnt}, {m_cyc, m_ins});
            check("rand_head", {log_bus.log_pc, log_bus.log_addr, log_bus.log_data}, hd);
            start   = ($urandom_range(0, 24) == 0);
            retire  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) pc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            instr   = ($urandom_range(0, 29) == 0) ? HALT : ($urandom() | 32'h8000_0000);
            wb_en   = ($urandom_range(0, 1) == 1);
            wb_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data = $urandom();
            log_bus.log_ready = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Parametrised run controller and writeback logger for the single-cycle MIPS core. It drives the core's synchronous reset for a programmable number of cycles, then counts cycles and retired instructions. It detects the end of the program (halt instruction or jump-to-self), enforces a cycle timeout, and streams register writebacks through a small FIFO with a valid/ready handshake. It replaces free-running clock/reset stimulus with a deterministic, self-terminating harness.

Parameters:
PC_W, 32, width of the pc input
CNT_W, 32, width of the cycle and instruction counters
RST_CYCLES, 4, number of cycles cpu_reset is held high (>=1)
STALL_LIMIT, 8, consecutive retires at an unchanged pc that count as halt (>=2)
TIMEOUT, 100000, maximum RUN cycles before timeout (<2^CNT_W)
HALT_INSTR, 32'h0000000c, instruction word that ends the run (syscall)
LOG_DEPTH, 4, writeback FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset of this block
start  in  1  one-cycle pulse that begins a run; accepted only in IDLE or DONE
cpu_reset  out  1  synchronous active-high reset to the core
pc  in  PC_W  core pc of the instruction retiring this cycle
instr  in  32  instruction word retiring this cycle
retire  in  1  an instruction retires this cycle
wb_en  in  1  register-file write enable
wb_addr  in  5  register-file write address
wb_data  in  32  register-file write data
running  out  1  state is RUN
done  out  1  run finished (halt or timeout); sticky until next start
timed_out  out  1  run ended by timeout; sticky until next start
overflow  out  1  a log entry was dropped; sticky until next start
cycle_cnt  out  CNT_W  cycles spent in RUN
instr_cnt  out  CNT_W  retired instructions in RUN
log_valid  out  1  FIFO head is valid
log_ready  in  1  consumer accepts the head this cycle
log_pc  out  PC_W  head entry pc
log_addr  out  5  head entry register
log_data  out  32  head entry data

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cpu_reset=1; running, done, timed_out and overflow=0; counters=0; FIFO empty; log_valid=0; log_pc/addr/data=0. Reset asserted mid-run aborts immediately with no log flush.
- States: IDLE, RST, RUN, DONE.
- IDLE/DONE + start -> RST: clear counters, flags and FIFO; load rst_cnt=RST_CYCLES-1. start in RST or RUN is ignored.
- RST: cpu_reset=1; decrement rst_cnt each cycle; at 0 -> RUN. cpu_reset is high for exactly RST_CYCLES cycles after start, and goes low on the first RUN cycle.
- RUN: cpu_reset=0; running=1; cycle_cnt+1 every cycle; instr_cnt+1 on each retire.
- Halt, evaluated only on retire:
  - instr==HALT_INSTR -> DONE. The halting instruction is counted and its writeback, if any, is logged.
  - Stall detector: same_cnt resets to 1 when pc differs from the last retired pc, and increments when it matches. Reaching STALL_LIMIT -> DONE.
- Timeout: in RUN, if cycle_cnt==TIMEOUT-1 and no halt occurs this cycle -> DONE with timed_out=1. Halt takes priority when both happen in the same cycle.
- DONE: done=1; cpu_reset=1 (core frozen); counters hold; FIFO keeps draining.
- In IDLE/RST/DONE, retire and wb_en are ignored.
- Log push condition: RUN & retire & wb_en & wb_addr!=0. Entry is {pc, wb_addr, wb_data}.
- Log pop condition: log_valid & log_ready. Head is registered; log_valid=!empty. log_* hold stable while valid and not popped.
- Simultaneous push and pop when full: both succeed, count unchanged.
- Push when full without pop: entry dropped, overflow=1.
- Pointers wrap modulo LOG_DEPTH; count is $clog2(LOG_DEPTH)+1 bits.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- Apply reset=0, then release; pulse start at cycle 0 -> cpu_reset high for cycles 1-4, running=1 from cycle 5, cycle_cnt=0 on the first RUN cycle.
- Retire pcs 0x3000, 0x3004, 0x3008, then instr=0x0000000c at 0x300c -> done=1 the next cycle, instr_cnt=4, timed_out=0, cpu_reset=1.
- Retire pc 0x3010 repeatedly (beq self-loop), STALL_LIMIT=8 -> done after the 8th retire, instr_cnt=8.
- TIMEOUT=20 with no halt -> done=1, timed_out=1, cycle_cnt=19; halt arriving on cycle 19 instead -> timed_out=0.
- log_ready=0, six writebacks ($1..$6, data 0x11..0x66), LOG_DEPTH=4 -> overflow=1. Then log_ready=1 -> pops $1..$4 in order and log_valid drops.
- wb_addr=0 writeback is not logged. Push and pop while full -> no overflow. reset=0 in mid-RUN -> all outputs return to reset values within the same cycle.
